q65_bus_arbiter: RTL and testbench
==================================

Name: q65_bus_arbiter

Overview:
- Sequences the two-bus fabric: the left driver (busL), the right driver (busR) and the bidirectional bridge between them.
- Two requesters each ask to own their local bus, optionally with the bridge passing their data to the far bus.
- The block grants exactly one owner at a time and inserts dead turnaround cycles between owners, so no tristate net is ever driven from both sides.
- Round-robin fairness, with optional preemption of long holders.

Parameters:
- TURN_CYCLES, 1, dead cycles between any grant release and the next grant (minimum 1; 0 is treated as 1).
- MAX_HOLD, 0, maximum consecutive grant cycles while the other side is requesting; 0 = unlimited.
- HOLD_W, 8, width of the hold counter (must hold MAX_HOLD).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reqL  in  1  left requester wants busL
- xferL  in  1  with reqL: also pass busL to busR (bridge pass12)
- reqR  in  1  right requester wants busR
- xferR  in  1  with reqR: also pass busR to busL (bridge pass21)
- gntL  out  1  left owns the bus; drives the left driver's enableOut
- gntR  out  1  right owns the bus; drives the right driver's enableOut
- pass12  out  1  bridge L->R enable
- pass21  out  1  bridge R->L enable
- preempt  out  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0; state IDLE; lastGnt = R, so L wins the first tie; hold counter 0.
- States: IDLE, OWN_L, OWN_R, TURN. All outputs are registered.
- IDLE:
  - reqL only -> OWN_L.
  - reqR only -> OWN_R.
  - Both -> the side that is not lastGnt.
  - Neither -> stay in IDLE.
- Grant latency: gnt is high on the first cycle after req is sampled in IDLE.
- OWN_L:
  - gntL = 1.
  - pass12 = xferL, re-sampled every cycle; xferL may change mid-grant.
  - gntR = pass21 = 0.
  - lastGnt <= L.
- OWN_R: mirror of OWN_L (gntR = 1, pass21 = xferR, gntL = pass12 = 0, lastGnt <= R).
- Exit from OWN_x:
  - reqx falling -> next cycle all four enables are 0; enter TURN.
  - Preemption: MAX_HOLD != 0, the other side is requesting, and holdCnt == MAX_HOLD-1 -> exit to TURN and pulse preempt for that one cycle.
  - holdCnt counts grant cycles and clears on entry to OWN_x.
  - holdCnt saturates rather than wraps.
- TURN:
  - All enables 0.
  - Lasts exactly TURN_CYCLES cycles, then re-arbitrates with the IDLE rules.
  - Result: a grant follows TURN directly (no IDLE cycle in between) if any request is pending, else the state goes to IDLE.
- Invariants:
  - At most one of gntL/gntR is high.
  - pass12 implies gntL; pass21 implies gntR.
  - pass12 and pass21 are never both high.
  - After any gnt falls, no gnt rises for at least TURN_CYCLES cycles.
- Requests and xfer: xferx is ignored while reqx = 0. A request held continuously is re-granted after TURN if it remains the only requester.
- Reset mid-grant: all enables drop on the cycle after reset is sampled high. No turnaround is owed after reset.

Optional Feature:
- Macro: Q65_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs grantCntL and grantCntR (16 bits each), counting grant entries; they wrap at 0xFFFF -> 0.
  - Adds output contention (1 bit), sticky, set if any invariant is ever violated; a checker against the registered outputs.
  - All three reset to 0.
- Without the macro: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package q65_bus_pkg:
  - State enum (IDLE, OWN_L, OWN_R, TURN).
  - Side encoding (SIDE_L = 0, SIDE_R = 1).
  - Default turnaround constant.
- One natural sub-module, q65_turn_timer: down-counter loaded with TURN_CYCLES, asserting done. It is reusable for other tristate buses in the core.

Test Plan:
- Reset and single request: reset, then reqL = 1, xferL = 1 at cycle 2 -> gntL = 1 and pass12 = 1 at cycle 3, gntR = pass21 = 0; drop reqL at cycle 6 -> all enables 0 at cycle 7.
- Tie after reset: reqL = reqR = 1 simultaneously -> L granted first. L releases -> TURN_CYCLES = 2 gives dead cycles, then gntR with no IDLE cycle.
- Round robin: both requesting, each releases after 3 cycles -> grant sequence L, R, L, R, each separated by exactly TURN_CYCLES idle enables.
- Preemption: MAX_HOLD = 4; L held indefinitely, R requests -> gntL high for exactly 4 cycles, preempt pulses once, gntR follows after the turnaround.
- xfer toggling: during OWN_R, toggle xferR 0/1/0 -> pass21 follows one cycle later; pass12 stays 0 throughout.
- Reset mid-grant, plus stats: assert reset during OWN_L -> enables 0 next cycle. With Q65_ARB_STATS_EN, after 3 L grants and 2 R grants, grantCntL = 3, grantCntR = 2, contention = 0.

Source files
------------

// File: rtl/q65_bus_pkg.sv
// Shared types and constants for the two-bus fabric arbiter: state encoding,
// side encoding, default turnaround length and the tie-break arbitration rule.
package q65_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_L = 2'd1,
        OWN_R = 2'd2,
        TURN  = 2'd3
    } state_t;

    localparam logic SIDE_L = 1'b0;
    localparam logic SIDE_R = 1'b1;

    localparam int DEFAULT_TURN_CYCLES = 1;

    // Winner of an arbitration round; on a tie the side that did not own last wins.
    function automatic state_t arb_pick(input logic req_l, input logic req_r,
                                        input logic last_gnt);
        state_t pick;
        pick = IDLE;
        if (req_l && req_r) begin
            pick = (last_gnt == SIDE_L) ? OWN_R : OWN_L;
        end else if (req_l) begin
            pick = OWN_L;
        end else if (req_r) begin
            pick = OWN_R;
        end
        return pick;
    endfunction

endpackage

// File: rtl/q65_turn_timer.sv
// Turnaround down-counter for tristate buses. Held at its load value while
// load is high; counts down otherwise and flags done at terminal count zero.
// A CYCLES of 0 behaves as 1 so there is always at least one dead cycle.
module q65_turn_timer
    import q65_bus_pkg::*;
#(
    parameter int CYCLES = DEFAULT_TURN_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int EFF = (CYCLES < 1) ? 1 : CYCLES;
    localparam int W   = (EFF > 1) ? $clog2(EFF) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(EFF - 1);

    logic [W-1:0] cnt;

    // Preload outside the dead window, then count down to terminal zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/q65_bus_arbiter.sv
// Owner arbiter for the busL / busR / bridge fabric. Grants one side at a time,
// inserts TURN_CYCLES dead cycles between owners, round-robin on ties, and can
// preempt a holder after MAX_HOLD cycles when the other side is waiting.
// Optional statistics and invariant checker: define Q65_ARB_STATS_EN.
//
//   state | meaning
//   IDLE  | no owner, no request pending
//   OWN_L | left owns busL, pass12 follows xferL
//   OWN_R | right owns busR, pass21 follows xferR
//   TURN  | dead turnaround, all enables low
module q65_bus_arbiter
    import q65_bus_pkg::*;
#(
    parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES,
    parameter int MAX_HOLD    = 0,
    parameter int HOLD_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqL,
    input  logic        xferL,
    input  logic        reqR,
    input  logic        xferR,
    output logic        gntL,
    output logic        gntR,
    output logic        pass12,
    output logic        pass21,
    output logic        preempt,
    output logic        busy
`ifdef Q65_ARB_STATS_EN
    ,
    output logic [15:0] grantCntL,
    output logic [15:0] grantCntR,
    output logic        contention
`endif
);

    localparam bit PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
    // The counter parks at the preemption point so a competitor arriving late
    // in a long solo hold still ends it on the next cycle.
    localparam logic [HOLD_W-1:0] HOLD_SAT  = PREEMPT_EN ? HOLD_LAST : '1;

    state_t            state;
    state_t            pick;
    logic              last_gnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              turn_load;
    logic              turn_done;

    assign pick      = arb_pick(reqL, reqR, last_gnt);
    assign turn_load = (state != TURN);

    q65_turn_timer #(
        .CYCLES (TURN_CYCLES)
    ) u_turn_timer (
        .clk   (clk),
        .reset (reset),
        .load  (turn_load),
        .done  (turn_done)
    );

    // Ownership FSM with all enables registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= SIDE_R;
            hold_cnt <= '0;
            gntL     <= 1'b0;
            gntR     <= 1'b0;
            pass12   <= 1'b0;
            pass21   <= 1'b0;
            preempt  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (state == IDLE || turn_done) begin
                        state    <= pick;
                        gntL     <= (pick == OWN_L);
                        gntR     <= (pick == OWN_R);
                        pass12   <= (pick == OWN_L) && xferL;
                        pass21   <= (pick == OWN_R) && xferR;
                        busy     <= (pick != IDLE);
                        hold_cnt <= '0;
                        if (pick == OWN_L) last_gnt <= SIDE_L;
                        if (pick == OWN_R) last_gnt <= SIDE_R;
                    end else begin
                        gntL   <= 1'b0;
                        gntR   <= 1'b0;
                        pass12 <= 1'b0;
                        pass21 <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                OWN_L: begin
                    if (!reqL || (PREEMPT_EN && reqR && hold_cnt == HOLD_LAST)) begin
                        state   <= TURN;
                        gntL    <= 1'b0;
                        pass12  <= 1'b0;
                        preempt <= reqL;
                    end else begin
                        pass12   <= xferL;
                        last_gnt <= SIDE_L;
                        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    gntR   <= 1'b0;
                    pass21 <= 1'b0;
                    busy   <= 1'b1;
                end
                OWN_R: begin
                    if (!reqR || (PREEMPT_EN && reqL && hold_cnt == HOLD_LAST)) begin
                        state   <= TURN;
                        gntR    <= 1'b0;
                        pass21  <= 1'b0;
                        preempt <= reqR;
                    end else begin
                        pass21   <= xferR;
                        last_gnt <= SIDE_R;
                        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    gntL   <= 1'b0;
                    pass12 <= 1'b0;
                    busy   <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    gntL   <= 1'b0;
                    gntR   <= 1'b0;
                    pass12 <= 1'b0;
                    pass21 <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef Q65_ARB_STATS_EN
    localparam int TURN_EFF = (TURN_CYCLES < 1) ? 1 : TURN_CYCLES;
    localparam logic [15:0] QUIET_MIN = 16'(TURN_EFF);

    logic        prev_l;
    logic        prev_r;
    logic [15:0] quiet_cnt;
    logic        any_now;
    logic        any_prev;
    logic        violation;

    assign any_now  = gntL | gntR;
    assign any_prev = prev_l | prev_r;
    // Checks the registered enables: exclusivity, bridge implies grant, and
    // enough dead cycles between one owner releasing and the next rising.
    assign violation = (gntL && gntR) || (pass12 && !gntL) || (pass21 && !gntR)
                    || (pass12 && pass21)
                    || (prev_l && !gntL && gntR) || (prev_r && !gntR && gntL)
                    || (any_now && !any_prev && quiet_cnt < QUIET_MIN);

    // Grant-entry counters and sticky contention flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_l     <= 1'b0;
            prev_r     <= 1'b0;
            quiet_cnt  <= QUIET_MIN;
            grantCntL  <= '0;
            grantCntR  <= '0;
            contention <= 1'b0;
        end else begin
            prev_l <= gntL;
            prev_r <= gntR;
            if (gntL && !prev_l) grantCntL <= grantCntL + 16'd1;
            if (gntR && !prev_r) grantCntR <= grantCntR + 16'd1;
            if (any_prev && !any_now) begin
                quiet_cnt <= 16'd1;
            end else if (!any_now && quiet_cnt < QUIET_MIN) begin
                quiet_cnt <= quiet_cnt + 16'd1;
            end
            if (violation) contention <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_q65_bus_arbiter.sv
// Directed bench for q65_bus_arbiter with TURN_CYCLES = 2 and MAX_HOLD = 4.
module tb_q65_bus_arbiter;

    logic clk;
    logic reset;
    logic reqL, xferL, reqR, xferR;
    logic gntL, gntR, pass12, pass21, preempt, busy;
`ifdef Q65_ARB_STATS_EN
    logic [15:0] grantCntL, grantCntR;
    logic        contention;
`endif

    int tests = 0;
    int fails = 0;

    q65_bus_arbiter #(
        .TURN_CYCLES (2),
        .MAX_HOLD    (4),
        .HOLD_W      (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqL    (reqL),
        .xferL   (xferL),
        .reqR    (reqR),
        .xferR   (xferR),
        .gntL    (gntL),
        .gntR    (gntR),
        .pass12  (pass12),
        .pass21  (pass21),
        .preempt (preempt),
        .busy    (busy)
`ifdef Q65_ARB_STATS_EN
        ,
        .grantCntL  (grantCntL),
        .grantCntR  (grantCntR),
        .contention (contention)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       rl;
        logic       xl;
        logic       rr;
        logic       xr;
        logic [5:0] exp;   // {gntL, gntR, pass12, pass21, preempt, busy}
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic rl, input logic xl,
                                input logic rr, input logic xr, input logic [5:0] exp);
        vec_t v;
        v.rst = rst; v.rl = rl; v.xl = xl; v.rr = rr; v.xr = xr; v.exp = exp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rl, input logic xl,
                         input logic rr, input logic xr);
        reset = rst; reqL = rl; xferL = xl; reqR = rr; xferR = xr;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // rst rl xl rr xr  -> gL gR p12 p21 pre busy
        vecs[0]  = mk(1, 0, 0, 0, 0, 6'b000000);
        vecs[1]  = mk(1, 0, 0, 0, 0, 6'b000000);
        vecs[2]  = mk(0, 0, 0, 0, 0, 6'b000000);
        vecs[3]  = mk(0, 1, 1, 0, 0, 6'b101001);
        vecs[4]  = mk(0, 1, 1, 0, 0, 6'b101001);
        vecs[5]  = mk(0, 1, 0, 0, 0, 6'b100001);
        vecs[6]  = mk(0, 1, 1, 0, 1, 6'b101001);
        vecs[7]  = mk(0, 0, 1, 0, 0, 6'b000001);
        vecs[8]  = mk(0, 0, 0, 0, 0, 6'b000001);
        vecs[9]  = mk(0, 0, 0, 0, 0, 6'b000000);
        vecs[10] = mk(0, 0, 0, 0, 0, 6'b000000);
        vecs[11] = mk(1, 1, 0, 1, 0, 6'b000000);
        vecs[12] = mk(0, 1, 0, 1, 0, 6'b100001);
        vecs[13] = mk(0, 1, 0, 1, 0, 6'b100001);
        vecs[14] = mk(0, 0, 0, 1, 0, 6'b000001);
        vecs[15] = mk(0, 0, 0, 1, 0, 6'b000001);
        vecs[16] = mk(0, 0, 0, 1, 1, 6'b010101);
        vecs[17] = mk(0, 0, 0, 1, 0, 6'b010001);
        vecs[18] = mk(0, 0, 1, 1, 1, 6'b010101);
        vecs[19] = mk(0, 0, 0, 1, 0, 6'b010001);
        vecs[20] = mk(1, 0, 0, 1, 0, 6'b000000);
        vecs[21] = mk(0, 0, 0, 1, 0, 6'b010001);
        vecs[22] = mk(0, 0, 0, 0, 0, 6'b000001);
        vecs[23] = mk(0, 0, 0, 0, 0, 6'b000001);
        vecs[24] = mk(0, 0, 0, 0, 0, 6'b000000);
        vecs[25] = mk(0, 1, 1, 0, 0, 6'b101001);
        vecs[26] = mk(1, 1, 1, 0, 0, 6'b000000);
        vecs[27] = mk(0, 0, 0, 0, 0, 6'b000000);

        drive(1, 0, 0, 0, 0);

        // Table: single request, xfer re-sampling, tie after reset, turnaround,
        // pass21 toggling, reset mid-grant on both sides.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rl, vecs[i].xl, vecs[i].rr, vecs[i].xr);
            tick();
            check($sformatf("vec%0d outputs", i),
                  16'({gntL, gntR, pass12, pass21, preempt, busy}), 16'(vecs[i].exp));
        end

        // Round robin: each owner keeps its grant 3 cycles, then releases once.
        drive(1, 0, 0, 0, 0);
        tick();
        for (int c = 0; c <= 20; c++) begin
            logic rl, rr, el, er;
            rl = !(c == 3 || c == 13 || c >= 18);
            rr = !(c == 8 || c >= 18);
            el = (c <= 2) || (c >= 10 && c <= 12);
            er = (c >= 5 && c <= 7) || (c >= 15 && c <= 17);
            drive(0, rl, 0, rr, 0);
            tick();
            check($sformatf("rr c%0d gnt", c), 16'({gntL, gntR}), 16'({el, er}));
        end
        check("rr idle busy", 16'(busy), 16'd0);

        // Third left grant, then statistics after 3 L and 2 R entries.
        drive(0, 1, 0, 0, 0);
        tick();
        check("extra L gnt", 16'(gntL), 16'd1);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        check("extra L idle", 16'({gntL, gntR, busy}), 16'd0);
`ifdef Q65_ARB_STATS_EN
        check("grantCntL", grantCntL, 16'd3);
        check("grantCntR", grantCntR, 16'd2);
        check("contention", 16'(contention), 16'd0);
`endif

        // Preemption: both keep requesting; each holder is cut after 4 cycles.
        drive(1, 0, 0, 0, 0);
        tick();
        begin
            int pre_seen;
            pre_seen = 0;
            for (int p = 0; p <= 12; p++) begin
                logic el, er, ep;
                el = (p <= 3) || (p == 12);
                er = (p >= 6 && p <= 9);
                ep = (p == 4) || (p == 10);
                drive(0, 1, 0, (p != 0), 0);
                tick();
                if (preempt) pre_seen++;
                check($sformatf("pre p%0d", p), 16'({gntL, gntR, preempt}), 16'({el, er, ep}));
            end
            check("preempt pulses", 16'(pre_seen), 16'd2);
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        check("final idle", 16'({gntL, gntR, pass12, pass21, preempt, busy}), 16'd0);
`ifdef Q65_ARB_STATS_EN
        check("contention end", 16'(contention), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
